set_assoc_cache: RTL and testbench
==================================

Name: set_assoc_cache

Overview:
Parametrised N-way set-associative write-back, write-allocate data cache with multi-word lines, byte strobes, dirty tracking and true-LRU replacement. Sits between the core load/store unit (valid/ready request, valid response) and the memory bus (valid/ready line request, valid line response). It replaces the bare tag/data array with a complete controller: lookup, victim selection, writeback, refill and replay.

Parameters:
ADDR_SIZE, 32, byte address width
NUM_SETS, 16, sets (power of 2)
NUM_WAYS, 4, ways per set (power of 2, >=2)
WORDS_PER_LINE, 4, words per line (power of 2)
WORD_SIZE, 32, word width in bits (multiple of 8)

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req_valid  in  1  core request valid
cpu_req_ready  out  1  cache can accept a request
cpu_req_write  in  1  1=store, 0=load
cpu_req_addr  in  ADDR_SIZE  byte address
cpu_req_wdata  in  WORD_SIZE  store data
cpu_req_wstrb  in  WORD_SIZE/8  store byte enables
cpu_resp_valid  out  1  one-cycle response pulse
cpu_resp_rdata  out  WORD_SIZE  load data; word value after merge for stores
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=writeback, 0=refill
mem_req_addr  out  ADDR_SIZE  line-aligned address
mem_req_wdata  out  WORD_SIZE*WORDS_PER_LINE  victim line (word 0 in LSBs)
mem_resp_valid  in  1  refill data valid
mem_resp_rdata  in  WORD_SIZE*WORDS_PER_LINE  refill line
hit_count  out  32  saturating hit counter
miss_count  out  32  saturating miss counter

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Address split, LSB first: byte offset log2(WORD_SIZE/8), word offset log2(WORDS_PER_LINE), set log2(NUM_SETS), tag = remainder.
- Reset state: all valid and dirty bits 0. LRU age of way i = i in every set; the highest age is LRU. FSM = IDLE. cpu_resp_valid=0, mem_req_valid=0, counters=0. cpu_req_ready=0 while rst is high.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT.
- IDLE: cpu_req_ready=1. A request is captured when valid&&ready, then -> LOOKUP. In every other state cpu_req_ready=0.
- LOOKUP, hit: a load reads the word. A store merges wdata bytes per wstrb into the word and sets dirty. Hit way becomes age 0; ways younger than it age by 1. cpu_resp_valid pulses on the next cycle. hit_count++. -> IDLE. Hit latency is 2 cycles from acceptance to resp_valid.
- LOOKUP, miss: miss_count++. Victim = lowest-index invalid way, else the way with max age. Victim dirty -> WRITEBACK, else -> REFILL_REQ. Counting happens once per request; the replay after refill is not counted.
- WRITEBACK: mem_req_valid=1, write=1, addr={victim tag,set,0}, wdata=victim line. Hold until mem_req_ready, then -> REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, write=0, addr=line-aligned request address. Hold until ready, then -> REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid, write the line into the victim way: valid=1, dirty=0, new tag. -> LOOKUP, which replays as a hit and updates LRU there.
- mem_req_* outputs stay stable while valid and not ready. mem_resp_valid outside REFILL_WAIT is ignored.
- Counters saturate at 0xFFFF_FFFF.
- Reset mid-operation abandons the transaction: mem_req_valid drops in the cycle after rst, and no partial line is written.

Decomposition:
- Package cache_pkg holds:
  - the state enum;
  - address field width functions (byte/word offset, set, tag);
  - typedef cache_line_t {data, tag, valid, dirty}.
- Sub-module cache_lru holds the per-set age array. Interface: set index, touch enable, touched way, and victim-select output (first invalid, else max age). It is reset to age i for way i.

Test Plan:
Default parameters: set=addr[7:4], tag=addr[31:8].
- Cold load 0x0000_0104 -> mem read req addr 0x0000_0100. Return line {w3..w0}={0xD,0xC,0xB,0xA} -> rdata 0xB, miss_count=1.
- Load 0x0000_0108 after that -> rdata 0xC exactly 2 cycles after acceptance, no mem_req_valid, hit_count=1.
- Store 0x0000_0100 wdata 0xAABBCCDD wstrb 4'b0011 -> response; then load 0x0000_0100 -> 0x0000CCDD.
- After reset, load tags 1,2,3,4 in set 0 (0x100,0x200,0x300,0x400), then load 0x100, then 0x500 -> the clean victim is tag 2's way: no writeback, only a refill at 0x500. A following load of 0x200 misses.
- Store 0x0000_0204 wdata 0x12345678, then force eviction of tag 2 -> mem write req addr 0x0000_0200 with word1=0x12345678 precedes the refill request. Hold mem_req_ready low 5 cycles -> request signals stable.
- Assert rst in REFILL_WAIT -> mem_req_valid=0 and cpu_req_ready=1 after release. Reloading the same address misses again, and counters are 0 before that reload.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache: controller state
// encoding, address field width helpers and the stored line record.
package cache_pkg;

  // Default cache geometry; the line record below is sized from it.
  localparam int unsigned CACHE_ADDR_SIZE      = 32;
  localparam int unsigned CACHE_NUM_SETS       = 16;
  localparam int unsigned CACHE_NUM_WAYS       = 4;
  localparam int unsigned CACHE_WORDS_PER_LINE = 4;
  localparam int unsigned CACHE_WORD_SIZE      = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL_REQ,
    REFILL_WAIT
  } cache_state_e;

  // Address split, LSB first: byte offset, word offset, set, tag.
  function automatic int unsigned byte_off_w(input int unsigned word_size);
    return 32'($clog2(word_size / 8));
  endfunction

  function automatic int unsigned word_off_w(input int unsigned words_per_line);
    return 32'($clog2(words_per_line));
  endfunction

  function automatic int unsigned set_w(input int unsigned num_sets);
    return 32'($clog2(num_sets));
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_size,
                                        input int unsigned num_sets,
                                        input int unsigned words_per_line,
                                        input int unsigned word_size);
    return addr_size - byte_off_w(word_size) - word_off_w(words_per_line)
           - set_w(num_sets);
  endfunction

  localparam int unsigned CACHE_LINE_BITS = CACHE_WORD_SIZE * CACHE_WORDS_PER_LINE;
  localparam int unsigned CACHE_TAG_BITS  = tag_w(CACHE_ADDR_SIZE, CACHE_NUM_SETS,
                                                  CACHE_WORDS_PER_LINE, CACHE_WORD_SIZE);

  // One stored line: word 0 of data sits in the LSBs.
  typedef struct packed {
    logic [CACHE_LINE_BITS-1:0] data;
    logic [CACHE_TAG_BITS-1:0]  tag;
    logic                       valid;
    logic                       dirty;
  } cache_line_t;

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracker for every set of the cache.
// Ports: clk/rst (sync, active-high); set_idx selects the set for both the
// update and the victim query; touch/touch_way make a way most recent;
// valid_bits are the valid flags of the selected set; victim_way_c is the
// lowest-index invalid way, else the way holding the maximum age.
module cache_lru #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned SET_W   = 32'($clog2(NUM_SETS)),
  localparam int unsigned WAY_W   = 32'($clog2(NUM_WAYS))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] set_idx,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [NUM_WAYS-1:0] valid_bits,
  output logic [WAY_W-1:0] victim_way_c
);

  // Ages always form a permutation of 0..NUM_WAYS-1 within a set.
  logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic             found;

  // Touched way becomes age 0; ways younger than it age by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way) begin
          age_q[set_idx][w] <= '0;
        end else if (age_q[set_idx][w] < age_q[set_idx][touch_way]) begin
          age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
        end
      end
    end
  end

  // Victim: first invalid way, otherwise the oldest way.
  always_comb begin
    victim_way_c = '0;
    found        = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!valid_bits[w] && !found) begin
        victim_way_c = WAY_W'(w);
        found        = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (age_q[set_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
          victim_way_c = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache controller.
// Ports: clk/rst (sync, active-high); cpu_req_* valid/ready request from the
// load/store unit; cpu_resp_* one-cycle response pulse with load data or the
// merged store word; mem_req_* valid/ready line request (writeback or refill,
// line-aligned address, victim line with word 0 in LSBs); mem_resp_* refill
// line; hit_count/miss_count saturating per-request counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_SIZE      = CACHE_ADDR_SIZE,
  parameter int unsigned NUM_SETS       = CACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS       = CACHE_NUM_WAYS,
  parameter int unsigned WORDS_PER_LINE = CACHE_WORDS_PER_LINE,
  parameter int unsigned WORD_SIZE      = CACHE_WORD_SIZE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cpu_req_valid,
  output logic                                cpu_req_ready,
  input  logic                                cpu_req_write,
  input  logic [ADDR_SIZE-1:0]                cpu_req_addr,
  input  logic [WORD_SIZE-1:0]                cpu_req_wdata,
  input  logic [WORD_SIZE/8-1:0]              cpu_req_wstrb,
  output logic                                cpu_resp_valid,
  output logic [WORD_SIZE-1:0]                cpu_resp_rdata,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_req_write,
  output logic [ADDR_SIZE-1:0]                mem_req_addr,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_req_wdata,
  input  logic                                mem_resp_valid,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_resp_rdata,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count
);

  localparam int unsigned BO_W   = byte_off_w(WORD_SIZE);
  localparam int unsigned WO_W   = word_off_w(WORDS_PER_LINE);
  localparam int unsigned SET_W  = set_w(NUM_SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_SIZE, NUM_SETS, WORDS_PER_LINE, WORD_SIZE);
  localparam int unsigned WAY_W  = 32'($clog2(NUM_WAYS));
  localparam int unsigned OFF_W  = BO_W + WO_W;
  localparam int unsigned STRB_W = WORD_SIZE / 8;
  localparam int unsigned LINE_W = WORD_SIZE * WORDS_PER_LINE;
  localparam int unsigned RA_W   = ADDR_SIZE - BO_W;

  // The stored line record is sized from the package geometry.
  if (LINE_W != CACHE_LINE_BITS || TAG_W != CACHE_TAG_BITS) begin : g_bad_geometry
    $error("cache_line_t does not match the configured cache geometry");
  end

  cache_line_t  lines_q [NUM_SETS][NUM_WAYS];
  cache_state_e state_q, state_d;

  // Captured request; the byte offset is not needed past acceptance.
  logic              req_write_q;
  logic [RA_W-1:0]   req_addr_q;
  logic [WORD_SIZE-1:0] req_wdata_q;
  logic [STRB_W-1:0] req_wstrb_q;
  logic              replay_q, replay_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic [WO_W-1:0]  req_woff;
  logic [SET_W-1:0] req_set;
  logic [TAG_W-1:0] req_tag;

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [NUM_WAYS-1:0]  set_valid;
  logic [WAY_W-1:0]     victim_c;
  cache_line_t          hit_line, vic_line;
  logic [WORD_SIZE-1:0] old_word, merged_word;

  logic                 capture, hit_inc, miss_inc, lru_touch, arr_we;
  logic [WAY_W-1:0]     arr_way;
  cache_line_t          arr_line;
  logic                 mem_valid_d, mem_write_d, resp_valid_d;
  logic [ADDR_SIZE-1:0] mem_addr_d;
  logic [LINE_W-1:0]    mem_wdata_d;
  logic [WORD_SIZE-1:0] resp_rdata_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_req_addr[BO_W-1:0];

  assign req_woff = req_addr_q[0 +: WO_W];
  assign req_set  = req_addr_q[WO_W +: SET_W];
  assign req_tag  = req_addr_q[WO_W+SET_W +: TAG_W];

  // Ready is gated by rst so nothing is accepted while reset is held.
  assign cpu_req_ready = (state_q == IDLE) && !rst;

  cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk          (clk),
    .rst          (rst),
    .set_idx      (req_set),
    .touch        (lru_touch),
    .touch_way    (hit_way),
    .valid_bits   (set_valid),
    .victim_way_c (victim_c)
  );

  // Tag compare across the ways of the requested set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      set_valid[w] = lines_q[req_set][w].valid;
      if (lines_q[req_set][w].valid && (lines_q[req_set][w].tag == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Word select and byte-strobe merge for the hit line.
  always_comb begin
    hit_line    = lines_q[req_set][hit_way];
    vic_line    = lines_q[req_set][victim_c];
    old_word    = hit_line.data[req_woff*WORD_SIZE +: WORD_SIZE];
    merged_word = old_word;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (req_write_q && req_wstrb_q[b]) begin
        merged_word[b*8 +: 8] = req_wdata_q[b*8 +: 8];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    replay_d     = replay_q;
    victim_d     = victim_q;
    mem_valid_d  = mem_req_valid;
    mem_write_d  = mem_req_write;
    mem_addr_d   = mem_req_addr;
    mem_wdata_d  = mem_req_wdata;
    resp_valid_d = 1'b0;
    resp_rdata_d = cpu_resp_rdata;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    lru_touch    = 1'b0;
    arr_we       = 1'b0;
    arr_way      = hit_way;
    arr_line     = hit_line;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          capture  = 1'b1;
          replay_d = 1'b0;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          arr_we   = req_write_q;
          arr_line.data[req_woff*WORD_SIZE +: WORD_SIZE] = merged_word;
          arr_line.dirty = 1'b1;
          lru_touch    = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = merged_word;
          hit_inc      = !replay_q;
          state_d      = IDLE;
        end else begin
          miss_inc    = !replay_q;
          victim_d    = victim_c;
          mem_valid_d = 1'b1;
          if (vic_line.valid && vic_line.dirty) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {vic_line.tag, req_set, OFF_W'(0)};
            mem_wdata_d = vic_line.data;
            state_d     = WRITEBACK;
          end else begin
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, req_set, OFF_W'(0)};
            state_d     = REFILL_REQ;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_ready) begin
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, req_set, OFF_W'(0)};
          state_d     = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (mem_req_ready) begin
          mem_valid_d = 1'b0;
          state_d     = REFILL_WAIT;
        end
      end
      REFILL_WAIT: begin
        if (mem_resp_valid) begin
          arr_we         = 1'b1;
          arr_way        = victim_q;
          arr_line.data  = mem_resp_rdata;
          arr_line.tag   = req_tag;
          arr_line.valid = 1'b1;
          arr_line.dirty = 1'b0;
          replay_d       = 1'b1;
          state_d        = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_wstrb_q    <= '0;
      replay_q       <= 1'b0;
      victim_q       <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_write  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      state_q        <= state_d;
      replay_q       <= replay_d;
      victim_q       <= victim_d;
      cpu_resp_valid <= resp_valid_d;
      cpu_resp_rdata <= resp_rdata_d;
      mem_req_valid  <= mem_valid_d;
      mem_req_write  <= mem_write_d;
      mem_req_addr   <= mem_addr_d;
      mem_req_wdata  <= mem_wdata_d;
      if (capture) begin
        req_write_q <= cpu_req_write;
        req_addr_q  <= cpu_req_addr[ADDR_SIZE-1:BO_W];
        req_wdata_q <= cpu_req_wdata;
        req_wstrb_q <= cpu_req_wstrb;
      end
      if (hit_inc && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_inc && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

  // Line storage: one write per cycle (store hit or refill).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          lines_q[s][w].valid <= 1'b0;
          lines_q[s][w].dirty <= 1'b0;
        end
      end
    end else if (arr_we) begin
      lines_q[req_set][arr_way] <= arr_line;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache at default geometry
// (set = addr[7:4], tag = addr[31:8]) with a behavioural line memory.
module tb_set_assoc_cache;

  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [AW-1:0] cpu_req_addr;
  logic [WW-1:0] cpu_req_wdata;
  logic [3:0]    cpu_req_wstrb;
  logic          cpu_resp_valid;
  logic [WW-1:0] cpu_resp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_rdata;
  logic [31:0]   hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_cache #(
    .ADDR_SIZE(32), .NUM_SETS(16), .NUM_WAYS(4), .WORDS_PER_LINE(4), .WORD_SIZE(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural memory: preloaded lines, else word k of line A is A|k.
  logic [LW-1:0] mem_lines [logic [AW-1:0]];
  logic          log_wr   [$];
  logic [AW-1:0] log_addr [$];
  logic [LW-1:0] log_data [$];
  logic          pending = 1'b0;
  logic [AW-1:0] pend_addr;
  logic          resp_hold = 1'b0;
  int            stall_cycles = 0;
  int            stall_cnt = 0;
  logic [AW-1:0] snap_addr;
  logic          snap_write;
  logic [LW-1:0] snap_wdata;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (mem_lines.exists(a)) return mem_lines[a];
    return {a | 32'd3, a | 32'd2, a | 32'd1, a};
  endfunction

  // Handshake log and writeback storage.
  always @(posedge clk) begin
    if (rst) begin
      pending = 1'b0;
      stall_cnt = 0;
    end else if (mem_req_valid && mem_req_ready) begin
      log_wr.push_back(mem_req_write);
      log_addr.push_back(mem_req_addr);
      log_data.push_back(mem_req_wdata);
      stall_cnt = 0;
      if (mem_req_write) mem_lines[mem_req_addr] = mem_req_wdata;
      else begin
        pending   = 1'b1;
        pend_addr = mem_req_addr;
      end
    end
  end

  // Ready/response driver; stalled requests must hold steady.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pending && !resp_hold && !rst) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = line_of(pend_addr);
        pending = 1'b0;
      end
      if (mem_req_valid && !rst) begin
        if (stall_cnt < stall_cycles) begin
          if (stall_cnt == 0) begin
            snap_addr  = mem_req_addr;
            snap_write = mem_req_write;
            snap_wdata = mem_req_wdata;
          end else begin
            check("stall_valid", mem_req_valid, 1'b1);
            check("stall_addr",  mem_req_addr,  snap_addr);
            check("stall_write", mem_req_write, snap_write);
            check("stall_wdata", mem_req_wdata, snap_wdata);
          end
          stall_cnt++;
          mem_req_ready = 1'b0;
        end else begin
          mem_req_ready = 1'b1;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
    end
  end

  // One core access; lat counts negedges from the accepting edge to resp.
  task automatic cpu_access(input logic wr, input logic [AW-1:0] addr,
                            input logic [WW-1:0] wdata, input logic [3:0] strb,
                            output logic [WW-1:0] rdata, output int lat);
    int n;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    cpu_req_wstrb = strb;
    n = 0;
    while (!cpu_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", cpu_req_ready, 1'b1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 500) check("resp_timeout", cpu_resp_valid, 1'b1);
    rdata = cpu_resp_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    @(negedge clk);
    check("ready_in_rst", cpu_req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [WW-1:0] rd;
  int            lat;
  int            base;
  int            n;

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    cpu_req_wstrb = '0;
    mem_lines[32'h100] = {32'hD, 32'hC, 32'hB, 32'hA};
    repeat (3) @(negedge clk);
    check("ready_in_rst", cpu_req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",     cpu_req_ready, 1'b1);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_resp",      cpu_resp_valid, 1'b0);
    check("rst_hits",      hit_count, 32'd0);
    check("rst_misses",    miss_count, 32'd0);

    // Cold miss, then hit in the same line.
    base = log_addr.size();
    cpu_access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
    check("cold_rdata", rd, 32'hB);
    check("cold_req_wr", log_wr[base], 1'b0);
    check("cold_req_addr", log_addr[base], 32'h100);
    check("cold_misses", miss_count, 32'd1);
    check("cold_hits", hit_count, 32'd0);
    base = log_addr.size();
    cpu_access(1'b0, 32'h108, 32'h0, 4'h0, rd, lat);
    check("hit_rdata", rd, 32'hC);
    check("hit_latency", lat, 2);
    check("hit_no_mem", log_addr.size(), base);
    check("hit_hits", hit_count, 32'd1);

    // Partial store merge.
    cpu_access(1'b1, 32'h100, 32'hAABBCCDD, 4'b0011, rd, lat);
    check("st_resp", rd, 32'h0000CCDD);
    check("st_latency", lat, 2);
    cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check("st_readback", rd, 32'h0000CCDD);
    check("st_hits", hit_count, 32'd3);

    // LRU victim choice: tag 2 is oldest after touching tag 1.
    do_reset();
    cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    cpu_access(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
    cpu_access(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
    cpu_access(1'b0, 32'h400, 32'h0, 4'h0, rd, lat);
    check("fill_rdata", rd, 32'h400);
    cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check("lru_hit_rdata", rd, 32'hA);
    base = log_addr.size();
    cpu_access(1'b0, 32'h500, 32'h0, 4'h0, rd, lat);
    check("evict_rdata", rd, 32'h500);
    check("evict_one_req", log_addr.size(), base + 1);
    check("evict_req_wr", log_wr[base], 1'b0);
    check("evict_req_addr", log_addr[base], 32'h500);
    base = log_addr.size();
    cpu_access(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
    check("t2_missed", log_addr[base], 32'h200);
    check("lru_misses", miss_count, 32'd6);
    check("lru_hits", hit_count, 32'd1);

    // Dirty eviction with a stalled memory.
    cpu_access(1'b1, 32'h204, 32'h12345678, 4'b1111, rd, lat);
    check("st2_resp", rd, 32'h12345678);
    check("st2_hits", hit_count, 32'd2);
    cpu_access(1'b0, 32'h600, 32'h0, 4'h0, rd, lat);
    cpu_access(1'b0, 32'h700, 32'h0, 4'h0, rd, lat);
    cpu_access(1'b0, 32'h800, 32'h0, 4'h0, rd, lat);
    check("pre_wb_rdata", rd, 32'h800);
    base = log_addr.size();
    stall_cycles = 5;
    cpu_access(1'b0, 32'h900, 32'h0, 4'h0, rd, lat);
    stall_cycles = 0;
    check("wb_rdata", rd, 32'h900);
    check("wb_two_reqs", log_addr.size(), base + 2);
    check("wb_is_write", log_wr[base], 1'b1);
    check("wb_addr", log_addr[base], 32'h200);
    check("wb_data", log_data[base], 128'h00000203_00000202_12345678_00000200);
    check("wb_refill_wr", log_wr[base + 1], 1'b0);
    check("wb_refill_addr", log_addr[base + 1], 32'h900);
    check("wb_latency_gt", lat > 12, 1'b1);
    cpu_access(1'b0, 32'h204, 32'h0, 4'h0, rd, lat);
    check("wb_reload", rd, 32'h12345678);

    // Reset while waiting for a refill.
    do_reset();
    resp_hold = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 32'h300;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!pending && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("refill_req_timeout", pending, 1'b1);
    @(negedge clk);
    check("rw_mem_valid", mem_req_valid, 1'b0);
    check("rw_ready", cpu_req_ready, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_hold = 1'b0;
    @(negedge clk);
    check("abort_mem_valid", mem_req_valid, 1'b0);
    check("abort_ready", cpu_req_ready, 1'b1);
    check("abort_hits", hit_count, 32'd0);
    check("abort_misses", miss_count, 32'd0);
    base = log_addr.size();
    cpu_access(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
    check("abort_rdata", rd, 32'h300);
    check("abort_refill_addr", log_addr[base], 32'h300);
    check("abort_reload_miss", miss_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
